fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/fetch_unit_if.sv | 46 ++++
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions:
// datapath widths, reset vector and fetch-stage types.
package riscv_pkg;

  localparam int XLEN          = 64;
  localparam int INSTR_W       = 32;
  localparam int FETCH_ENTRY_W = XLEN + INSTR_W;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align4(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: memory request/response,
// redirect input and decoder handshake.
interface fetch_unit_if;
  import riscv_pkg::*;

  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [XLEN-1:0]    mem_req_addr;
  logic               mem_resp_valid;
  logic [INSTR_W-1:0] mem_resp_data;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [XLEN-1:0]    instr_pc;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    output instr_valid,
    output instr,
    output instr_pc,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data,
    input  redirect_valid,
    input  redirect_pc,
    input  instr_ready
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data,
    output redirect_valid,
    output redirect_pc,
    output instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer for the fetch stage:
// sync FIFO with flush and occupancy count.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i
                && ((cnt_q != FULL_C) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push)
                     - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push && !flush_i) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding
// memory request, credit-gated buffer, redirects.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] ra_q;
  logic [XLEN-1:0] ra_d;
  logic            out_q;
  logic            out_d;

  logic [CW-1:0] occ;
  logic [CW:0]   credit;
  logic          redir;
  logic          accept;
  logic          push;
  logic          pop;

  fetch_entry_t             wentry;
  fetch_entry_t             hentry;
  logic [FETCH_ENTRY_W-1:0] hraw;

  assign redir  = bus.redirect_valid;
  assign credit = {1'b0, occ}
                + {{CW{1'b0}}, out_q};

  // rst_n gates the request so it drops the
  // moment reset asserts, not at the next edge
  assign bus.mem_req_valid = rst_n
                          && (state_q == REQ)
                          && !redir
                          && (credit < DEPTH_C);
  assign bus.mem_req_addr  = pc_q;

  assign accept = bus.mem_req_valid
               && bus.mem_req_ready;
  assign push   = (state_q == WAIT)
               && bus.mem_resp_valid
               && !redir;
  assign pop    = bus.instr_valid
               && bus.instr_ready
               && !redir;

  assign wentry = '{instr: bus.mem_resp_data,
                    pc:    ra_q};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ra_d    = ra_q;
    out_d   = out_q;
    if (out_q && bus.mem_resp_valid) begin
      out_d = 1'b0;
    end
    if (accept) begin
      out_d = 1'b1;
      ra_d  = pc_q;
      pc_d  = pc_q + XLEN'(4);
    end
    unique case (state_q)
      REQ: begin
        if (accept) state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_resp_valid) state_d = REQ;
      end
      // leave once nothing is left in flight
      FLUSH: begin
        if (bus.mem_resp_valid || !out_q) begin
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
    if (redir) begin
      pc_d    = align4(bus.redirect_pc);
      state_d = (state_q == WAIT) ? FLUSH
                                  : state_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      ra_q    <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ra_q    <= ra_d;
      out_q   <= out_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redir),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .rdata_o (hraw),
    .count_o (occ)
  );

  assign hentry          = fetch_entry_t'(hraw);
  assign bus.instr_valid = (occ != '0);
  assign bus.instr       = bus.instr_valid
                         ? hentry.instr : '0;
  assign bus.instr_pc    = bus.instr_valid
                         ? hentry.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus
// random traffic against a stream-level reference.
`timescale 1ns/1ps
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [63:0] RPC = 64'h1000;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // memory model: one pending request with latency
  bit          mem_busy;
  int          mem_lat;
  logic [63:0] mem_addr;
  int          lat_fix = 1;
  bit          lat_rand = 0;
  bit          spur_en = 0;

  // stream model: next expected request and delivery pc
  logic [63:0] exp_req;
  logic [63:0] exp_deq;
  bit          prev_stall;
  logic [63:0] prev_addr;

  logic        o_req_v, o_acc, o_iv, o_deq, o_resp;
  logic [63:0] o_addr, o_ipc;
  logic [31:0] o_instr;
  int          tick_no;
  int          n_deq;
  logic [63:0] acc_q[$];
  int          acc_t[$];
  int          deq_t[$];

  function automatic logic [31:0] hash(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A17_C3E9
         ^ {a[15:0], a[31:16]};
  endfunction

  task automatic model_reset();
    mem_busy   = 0;
    mem_lat    = 0;
    mem_addr   = '0;
    exp_req    = RPC;
    exp_deq    = RPC;
    prev_stall = 0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
  endtask

  task automatic clear_log();
    acc_q.delete();
    acc_t.delete();
    deq_t.delete();
    tick_no = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b1;
    bus.mem_req_ready  = 1'b1;
    lat_fix = 1;
    model_reset();
    clear_log();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // one clock: drive memory, observe, check, advance model
  task automatic tick();
    logic [63:0] t;
    if (mem_busy && mem_lat == 0) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = hash(mem_addr);
    end else if (spur_en && !mem_busy
                 && $urandom_range(0, 19) == 0) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = $urandom;
    end else begin
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = $urandom;
    end
    #1;
    o_req_v = bus.mem_req_valid;
    o_addr  = bus.mem_req_addr;
    o_iv    = bus.instr_valid;
    o_ipc   = bus.instr_pc;
    o_instr = bus.instr;
    o_resp  = bus.mem_resp_valid && mem_busy;
    o_acc   = o_req_v && bus.mem_req_ready;
    o_deq   = o_iv && bus.instr_ready
           && !bus.redirect_valid;
    if (bus.redirect_valid) begin
      vectors++;
      if (o_req_v !== 1'b0) begin
        miscompares++;
        $display("FAIL req_on_redirect: got %b want 0", o_req_v);
      end
    end
    if (o_req_v) begin
      vectors++;
      if (o_addr[1:0] !== 2'b00) begin
        miscompares++;
        $display("FAIL addr_align: got %h want low bits 0", o_addr);
      end
    end
    if (o_req_v && prev_stall) begin
      vectors++;
      if (o_addr !== prev_addr) begin
        miscompares++;
        $display("FAIL addr_stable: got %h want %h", o_addr, prev_addr);
      end
    end
    if (o_acc) begin
      vectors++;
      if (o_addr !== exp_req) begin
        miscompares++;
        $display("FAIL req_addr: got %h want %h", o_addr, exp_req);
      end
      vectors++;
      if (mem_busy && !o_resp) begin
        miscompares++;
        $display("FAIL outstanding: got 2 want 1");
      end
    end
    if (o_deq) begin
      vectors++;
      if (o_ipc !== exp_deq
          || o_instr !== hash(exp_deq)) begin
        miscompares++;
        $display("FAIL deliver: got %h/%h want %h/%h",
                 o_ipc, o_instr, exp_deq, hash(exp_deq));
      end
    end
    if (o_resp) mem_busy = 0;
    else if (mem_busy && mem_lat > 0) mem_lat--;
    if (o_acc) begin
      mem_busy = 1;
      mem_addr = o_addr;
      mem_lat  = lat_rand ? int'($urandom_range(0, 2))
                          : lat_fix - 1;
      acc_q.push_back(o_addr);
      acc_t.push_back(tick_no);
      exp_req = exp_req + 64'd4;
    end
    if (o_deq) begin
      exp_deq = exp_deq + 64'd4;
      n_deq++;
      deq_t.push_back(tick_no);
    end
    if (bus.redirect_valid) begin
      t = bus.redirect_pc;
      exp_req = {t[63:2], 2'b00};
      exp_deq = {t[63:2], 2'b00};
    end
    prev_stall = o_req_v && !bus.mem_req_ready;
    prev_addr  = o_addr;
    tick_no++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b1;
    bus.mem_req_ready  = 1'b1;
    model_reset();
    clear_log();
    @(negedge clk);
    #1;
    vectors++;
    if (bus.mem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_valids: got %b%b want 00",
               bus.mem_req_valid, bus.instr_valid);
    end
    vectors++;
    if (bus.instr !== 32'h0 || bus.instr_pc !== 64'h0) begin
      miscompares++;
      $display("FAIL rst_instr: got %h/%h want 0/0",
               bus.instr, bus.instr_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++;
    if (o_req_v !== 1'b1 || o_addr !== RPC) begin
      miscompares++;
      $display("FAIL rst_first_req: got %b/%h want 1/%h",
               o_req_v, o_addr, RPC);
    end
  endtask

  task automatic test_basic();
    do_reset();
    repeat (12) tick();
    vectors++;
    if (acc_q.size() != 6) begin
      miscompares++;
      $display("FAIL basic_accepts: got %0d want 6", acc_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (acc_q.size() <= i
          || acc_q[i] !== RPC + 64'(4 * i)) begin
        miscompares++;
        $display("FAIL basic_addr%0d: got %h want %h", i,
                 (acc_q.size() > i) ? acc_q[i] : 64'hx,
                 RPC + 64'(4 * i));
      end
    end
    vectors++;
    if (deq_t.size() == 0 || acc_t.size() == 0
        || deq_t[0] - acc_t[0] < 2) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d want >=2",
               (deq_t.size() > 0 && acc_t.size() > 0)
               ? deq_t[0] - acc_t[0] : -1);
    end
    vectors++;
    if (deq_t.size() < 5) begin
      miscompares++;
      $display("FAIL basic_throughput: got %0d want >=5", deq_t.size());
    end
  endtask

  task automatic test_backpressure();
    int n0;
    bit got;
    do_reset();
    bus.instr_ready = 1'b0;
    repeat (20) tick();
    vectors++;
    if (acc_q.size() != DEPTH) begin
      miscompares++;
      $display("FAIL bp_accepts: got %0d want %0d", acc_q.size(), DEPTH);
    end
    vectors++;
    if (o_req_v !== 1'b0 || o_iv !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_hold: got req=%b iv=%b want 0/1", o_req_v, o_iv);
    end
    bus.instr_ready = 1'b1;
    n0 = n_deq;
    acc_q.delete();
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      if (acc_q.size() > 0) got = 1;
    end
    vectors++;
    if (!got || acc_q[0] !== 64'h1010) begin
      miscompares++;
      $display("FAIL bp_resume: got %h want 0000000000001010",
               got ? acc_q[0] : 64'hx);
    end
    repeat (10) tick();
    vectors++;
    if (n_deq - n0 < DEPTH) begin
      miscompares++;
      $display("FAIL bp_drain: got %0d want >=%0d", n_deq - n0, DEPTH);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    bus.instr_ready = 1'b0;
    repeat (3) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h2002;
    tick();
    vectors++;
    if (o_resp !== 1'b1) begin
      miscompares++;
      $display("FAIL rw_same_cycle_resp: got %b want 1", o_resp);
    end
    bus.redirect_valid = 1'b0;
    tick();
    vectors++;
    if (o_req_v !== 1'b0 || o_iv !== 1'b0) begin
      miscompares++;
      $display("FAIL rw_flush: got req=%b iv=%b want 0/0", o_req_v, o_iv);
    end
    tick();
    vectors++;
    if (o_req_v !== 1'b1 || o_addr !== 64'h2000 || o_iv !== 1'b0) begin
      miscompares++;
      $display("FAIL rw_restart: got %b/%h/%b want 1/2000/0",
               o_req_v, o_addr, o_iv);
    end
    bus.instr_ready = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_req_stall();
    do_reset();
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (o_req_v !== 1'b1 || o_addr !== RPC) begin
        miscompares++;
        $display("FAIL stall_%0d: got %b/%h want 1/%h", i, o_req_v, o_addr, RPC);
      end
    end
    bus.mem_req_ready = 1'b1;
    tick();
    tick();
    vectors++;
    if (acc_q.size() != 1 || o_req_v !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_accept: got %0d/%b want 1/0", acc_q.size(), o_req_v);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.instr_ready = 1'b0;
    lat_fix = 3;
    repeat (14) tick();
    #1;
    vectors++;
    if (bus.instr_valid !== 1'b1 || bus.mem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ar_pre: got iv=%b req=%b want 1/0",
               bus.instr_valid, bus.mem_req_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.instr_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ar_drop: got iv=%b req=%b want 0/0",
               bus.instr_valid, bus.mem_req_valid);
    end
    model_reset();
    lat_fix = 1;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++;
    if (o_req_v !== 1'b1 || o_addr !== RPC || o_iv !== 1'b0) begin
      miscompares++;
      $display("FAIL ar_restart: got %b/%h/%b want 1/%h/0",
               o_req_v, o_addr, o_iv, RPC);
    end
    repeat (6) tick();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    bus.redirect_valid = 1'b0;
    acc_q.delete();
    for (int i = 0; i < 12 && acc_q.size() < 2; i++) tick();
    vectors++;
    if (acc_q.size() < 2
        || acc_q[0] !== 64'hFFFF_FFFF_FFFF_FFFC
        || acc_q[1] !== 64'h0) begin
      miscompares++;
      $display("FAIL wrap: got %0d reqs %h %h want FFFFFFFFFFFFFFFC 0",
               acc_q.size(),
               (acc_q.size() > 0) ? acc_q[0] : 64'hx,
               (acc_q.size() > 1) ? acc_q[1] : 64'hx);
    end
    repeat (6) tick();
  endtask

  task automatic test_random();
    int n0;
    do_reset();
    lat_rand = 1;
    spur_en  = 1;
    n0 = n_deq;
    for (int i = 0; i < 1500; i++) begin
      bus.instr_ready    = ($urandom_range(0, 9) < 7);
      bus.mem_req_ready  = ($urandom_range(0, 9) < 7);
      bus.redirect_valid = ($urandom_range(0, 29) == 0);
      bus.redirect_pc    = ($urandom_range(0, 3) == 0)
                         ? {32'hFFFF_FFFF, 32'($urandom)}
                         : {32'h0, 32'($urandom)};
      tick();
    end
    bus.redirect_valid = 1'b0;
    lat_rand = 0;
    spur_en  = 0;
    vectors++;
    if (n_deq - n0 < 50) begin
      miscompares++;
      $display("FAIL random_progress: got %0d want >=50", n_deq - n0);
    end
  endtask

  initial begin
    n_deq = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_req_stall();
    test_async_reset();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
